// File: rtl/dsm_axi_pkg.sv
// Shared AXI4 constants, FSM state types and helpers for the DSM stream-to-memory path.
package dsm_axi_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic {
        AW_IDLE,
        AW_ADDR
    } aw_state_t;

    typedef enum logic {
        W_IDLE,
        W_DATA
    } w_state_t;

    // AxSIZE encoding: log2 of the bytes per beat.
    function automatic logic [2:0] axi_size(input int data_width);
        logic [2:0] size;
        size = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if ((8 << i) == data_width) begin
                size = 3'(i);
            end
        end
        return size;
    endfunction

endpackage

// File: rtl/dsm_sync_fifo.sv
// Synchronous show-ahead FIFO: extra-MSB pointers, registered flags and count,
// block-RAM storage whose head word is re-read every cycle into a register.
module dsm_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int ADDR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [WIDTH-1:0]  rd_data_reg;
    logic [ADDR_W:0]   wr_ptr_reg, wr_ptr_next;
    logic [ADDR_W:0]   rd_ptr_reg, rd_ptr_next;
    logic [ADDR_W:0]   count_reg;
    logic              empty_reg, full_reg;
    logic              empty_next, full_next;

    assign wr_ptr_next = wr_ptr_reg + (ADDR_W + 1)'(wr_en);
    assign rd_ptr_next = rd_ptr_reg + (ADDR_W + 1)'(rd_en);
    assign empty_next  = (wr_ptr_next == rd_ptr_next);
    assign full_next   = (wr_ptr_next[ADDR_W] != rd_ptr_next[ADDR_W]) &&
                         (wr_ptr_next[ADDR_W-1:0] == rd_ptr_next[ADDR_W-1:0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            empty_reg  <= 1'b1;
            full_reg   <= 1'b0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= wr_ptr_next - rd_ptr_next;
            empty_reg  <= empty_next;
            full_reg   <= full_next;
        end
    end

    // The head address is read every cycle, so a word written into the head slot
    // shows up one cycle later and the output tracks pops without bubbles.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg[ADDR_W-1:0]] <= wr_data;
        end
        rd_data_reg <= mem[rd_ptr_next[ADDR_W-1:0]];
    end

    assign rd_data = rd_data_reg;
    assign empty   = empty_reg;
    assign full    = full_reg;
    assign count   = count_reg;

endmodule

// File: rtl/dsm_axis_aximm_burst.sv
// Buffers AXI-Stream words and writes each one as an AXI4 INCR burst into a
// circular host region, tracking outstanding write responses and errors.
module dsm_axis_aximm_burst
    import dsm_axi_pkg::*;
#(
    parameter int AXIS_DATA_WIDTH = 512,
    parameter int AXI_DATA_WIDTH  = 64,
    parameter int AXI_ADDR_WIDTH  = 49,
    parameter int FIFO_DEPTH      = 128,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [AXIS_DATA_WIDTH-1:0]    s_axis_dsm_tdata,
    input  logic [AXIS_DATA_WIDTH/8-1:0]  s_axis_dsm_tkeep,
    input  logic                          s_axis_dsm_tvalid,
    output logic                          s_axis_dsm_tready,
    input  logic                          s_axis_dsm_tlast,
    output logic [AXI_ADDR_WIDTH-1:0]     m_axi_dsm_awaddr,
    output logic [7:0]                    m_axi_dsm_awlen,
    output logic [2:0]                    m_axi_dsm_awsize,
    output logic [1:0]                    m_axi_dsm_awburst,
    output logic [2:0]                    m_axi_dsm_awprot,
    output logic                          m_axi_dsm_awvalid,
    input  logic                          m_axi_dsm_awready,
    output logic [AXI_DATA_WIDTH-1:0]     m_axi_dsm_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0]   m_axi_dsm_wstrb,
    output logic                          m_axi_dsm_wlast,
    output logic                          m_axi_dsm_wvalid,
    input  logic                          m_axi_dsm_wready,
    input  logic [1:0]                    m_axi_dsm_bresp,
    input  logic                          m_axi_dsm_bvalid,
    output logic                          m_axi_dsm_bready,
    input  logic [AXI_ADDR_WIDTH-1:0]     base_addr,
    input  logic [AXI_ADDR_WIDTH-1:0]     region_size,
    input  logic                          clear,
    output logic                          wr_err,
    output logic [31:0]                   bursts_done,
    output logic [31:0]                   pkts_done,
    output logic                          idle
);

    localparam int RATIO      = AXIS_DATA_WIDTH / AXI_DATA_WIDTH;
    localparam int WORD_BYTES = AXIS_DATA_WIDTH / 8;
    localparam int KEEP_W     = AXIS_DATA_WIDTH / 8;
    localparam int STRB_W     = AXI_DATA_WIDTH / 8;
    localparam int FIFO_W     = AXIS_DATA_WIDTH + KEEP_W;
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;
    localparam int BEAT_W     = (RATIO > 1) ? $clog2(RATIO) : 1;

    generate
        if (RATIO < 1 || RATIO > 256 || (AXIS_DATA_WIDTH % AXI_DATA_WIDTH) != 0) begin : g_bad_ratio
            $error("AXIS_DATA_WIDTH must be 1..256 integer multiples of AXI_DATA_WIDTH");
        end
        if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 15) begin : g_bad_outstanding
            $error("MAX_OUTSTANDING must be in 1..15");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("FIFO_DEPTH must be a power of 2");
        end
    endgenerate

    aw_state_t                    aw_state_reg, aw_state_next;
    w_state_t                     w_state_reg, w_state_next;
    logic [BEAT_W-1:0]            beat_reg, beat_next;
    logic [CNT_W-1:0]             aw_ahead_reg, aw_ahead_next;
    logic [3:0]                   outstanding_reg, outstanding_next;
    logic [AXI_ADDR_WIDTH-1:0]    wr_offset_reg, awaddr_reg, offset_sum;
    logic                         aw_cond_reg, ready_en_reg, wr_err_reg;
    logic [31:0]                  bursts_done_reg, pkts_done_reg;

    logic                         fifo_push, fifo_pop, fifo_empty, fifo_full;
    logic [CNT_W-1:0]             fifo_count;
    logic [FIFO_W-1:0]            fifo_rd_data;
    logic [AXIS_DATA_WIDTH-1:0]   head_data;
    logic [KEEP_W-1:0]            head_keep;

    logic aw_hs, w_done, beat_last, aw_cond_now, aw_go, aw_load;
    logic b_proto_err, b_dec, b_is_err;

    dsm_sync_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (fifo_push),
        .wr_data ({s_axis_dsm_tdata, s_axis_dsm_tkeep}),
        .rd_en   (fifo_pop),
        .rd_data (fifo_rd_data),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .count   (fifo_count)
    );

    assign head_data = fifo_rd_data[FIFO_W-1 -: AXIS_DATA_WIDTH];
    assign head_keep = fifo_rd_data[KEEP_W-1:0];

    logic [AXI_DATA_WIDTH-1:0] data_slice [RATIO];
    logic [STRB_W-1:0]         strb_slice [RATIO];

    for (genvar gi = 0; gi < RATIO; gi++) begin : g_slice
        assign data_slice[gi] = head_data[gi*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
        assign strb_slice[gi] = head_keep[gi*STRB_W +: STRB_W];
    end

    assign s_axis_dsm_tready = ready_en_reg && !fifo_full;
    assign fifo_push         = s_axis_dsm_tvalid && s_axis_dsm_tready;
    assign aw_hs             = m_axi_dsm_awvalid && m_axi_dsm_awready;
    assign beat_last         = (beat_reg == BEAT_W'(RATIO - 1));
    assign w_done            = m_axi_dsm_wvalid && m_axi_dsm_wready && beat_last;
    assign fifo_pop          = w_done;

    assign b_proto_err = m_axi_dsm_bvalid && (outstanding_reg == 4'd0);
    assign b_dec       = m_axi_dsm_bvalid && !b_proto_err;
    assign b_is_err    = (m_axi_dsm_bresp == AXI_RESP_SLVERR) || (m_axi_dsm_bresp == AXI_RESP_DECERR);

    assign outstanding_next = outstanding_reg + 4'(aw_hs) - 4'(b_dec);
    assign aw_ahead_next    = aw_ahead_reg + CNT_W'(aw_hs) - CNT_W'(w_done);
    assign offset_sum       = wr_offset_reg + AXI_ADDR_WIDTH'(WORD_BYTES);

    // The live condition keeps issue safe; the registered copy adds the pipeline stage.
    assign aw_cond_now = (aw_ahead_reg < fifo_count) && (outstanding_reg < 4'(MAX_OUTSTANDING));
    assign aw_go       = aw_cond_now && aw_cond_reg;

    always_comb begin
        aw_state_next = aw_state_reg;
        aw_load       = 1'b0;
        case (aw_state_reg)
            AW_IDLE: begin
                if (aw_go) begin
                    aw_state_next = AW_ADDR;
                    aw_load       = 1'b1;
                end
            end
            AW_ADDR: begin
                if (m_axi_dsm_awready) begin
                    aw_state_next = AW_IDLE;
                end
            end
            default: aw_state_next = AW_IDLE;
        endcase
    end

    always_comb begin
        w_state_next = w_state_reg;
        beat_next    = beat_reg;
        case (w_state_reg)
            W_IDLE: begin
                if (aw_ahead_reg != '0) begin
                    w_state_next = W_DATA;
                    beat_next    = '0;
                end
            end
            W_DATA: begin
                if (m_axi_dsm_wready) begin
                    if (beat_last) begin
                        beat_next = '0;
                        if (aw_ahead_next == '0) begin
                            w_state_next = W_IDLE;
                        end
                    end else begin
                        beat_next = beat_reg + BEAT_W'(1);
                    end
                end
            end
            default: w_state_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_state_reg    <= AW_IDLE;
            w_state_reg     <= W_IDLE;
            beat_reg        <= '0;
            aw_ahead_reg    <= '0;
            outstanding_reg <= '0;
            wr_offset_reg   <= '0;
            awaddr_reg      <= '0;
            aw_cond_reg     <= 1'b0;
            ready_en_reg    <= 1'b0;
            wr_err_reg      <= 1'b0;
            bursts_done_reg <= '0;
            pkts_done_reg   <= '0;
        end else begin
            aw_state_reg    <= aw_state_next;
            w_state_reg     <= w_state_next;
            beat_reg        <= beat_next;
            aw_ahead_reg    <= aw_ahead_next;
            outstanding_reg <= outstanding_next;
            aw_cond_reg     <= aw_cond_now;
            ready_en_reg    <= 1'b1;
            if (aw_load) begin
                awaddr_reg <= base_addr + (clear ? '0 : wr_offset_reg);
            end
            // clear wins over an AW accepted in the same cycle: the next burst starts at base.
            if (clear) begin
                wr_offset_reg <= '0;
            end else if (aw_hs) begin
                wr_offset_reg <= (offset_sum >= region_size) ? '0 : offset_sum;
            end
            wr_err_reg <= (wr_err_reg && !clear) || (m_axi_dsm_bvalid && (b_is_err || b_proto_err));
            if (m_axi_dsm_bvalid) begin
                bursts_done_reg <= bursts_done_reg + 32'd1;
            end
            if (fifo_push && s_axis_dsm_tlast) begin
                pkts_done_reg <= pkts_done_reg + 32'd1;
            end
        end
    end

    assign m_axi_dsm_awaddr  = awaddr_reg;
    assign m_axi_dsm_awlen   = 8'(RATIO - 1);
    assign m_axi_dsm_awsize  = axi_size(AXI_DATA_WIDTH);
    assign m_axi_dsm_awburst = AXI_BURST_INCR;
    assign m_axi_dsm_awprot  = 3'b000;
    assign m_axi_dsm_awvalid = (aw_state_reg == AW_ADDR);
    assign m_axi_dsm_wvalid  = (w_state_reg == W_DATA);
    assign m_axi_dsm_wdata   = data_slice[beat_reg];
    assign m_axi_dsm_wstrb   = strb_slice[beat_reg];
    assign m_axi_dsm_wlast   = m_axi_dsm_wvalid && beat_last;
    assign m_axi_dsm_bready  = 1'b1;

    assign wr_err      = wr_err_reg;
    assign bursts_done = bursts_done_reg;
    assign pkts_done   = pkts_done_reg;
    assign idle        = fifo_empty && (aw_state_reg == AW_IDLE) && (w_state_reg == W_IDLE) &&
                         (outstanding_reg == 4'd0);

endmodule
